w5300_bus_arbiter: RTL

Shares the single W5300 host-bus driver between NUM_REQ register-access requesters. Requesters include the common-register configurator, the socket TCP-server configurator and the socket data-path engine. Each requester presents one 11-bit access word and one 16-bit write word. The word is {RD/WR flag, 10-bit register address}: bit 10 = 1 means write, 0 means read. The arbiter grants round-robin with an optional per-requester bus lock for atomic command/poll sequences, and guards every bus operation with a completion watchdog.

---
 rtl/w5300_bus_arbiter_pkg.sv | 37 +++
 rtl/w5300_bus_arbiter_if.sv | 31 +++
 rtl/w5300_rr_pick.sv | 21 ++
 rtl/w5300_bus_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/w5300_bus_arbiter_pkg.sv
// Shared types, constants and helpers for the W5300 host-bus arbiter.
package w5300_bus_arbiter_pkg;

  localparam int unsigned ACCESS_W   = 11;
  localparam int unsigned BUS_WR_BIT = 10;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned MAX_REQ    = 8;
  localparam int unsigned IDX_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  // Access word plus write data as latched toward the bus driver.
  typedef struct packed {
    logic [ACCESS_W-1:0] addr;
    logic [DATA_W-1:0]   wr_data;
  } bus_req_t;

  // Index of the first set bit of vec after last, wrapping modulo n.
  // Scanning from the far end lets the nearest candidate overwrite the others.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0]   last,
                                               input logic [MAX_REQ-1:0] vec,
                                               input int unsigned        n);
    logic [IDX_W-1:0] pick;
    int unsigned      idx;
    pick = last;
    for (int unsigned k = n; k >= 1; k--) begin
      idx = (32'(last) + k) % n;
      if (vec[IDX_W'(idx)]) pick = IDX_W'(idx);
    end
    return pick;
  endfunction

endpackage

// File: rtl/w5300_bus_arbiter_if.sv
// Requester/driver signal bundle around the W5300 bus arbiter.
interface w5300_bus_arbiter_if
  import w5300_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
);
  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ-1:0]          lock;
  logic [NUM_REQ*ACCESS_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0]   req_wr_data;
  logic [NUM_REQ-1:0]          grant;
  logic [NUM_REQ-1:0]          op_done;
  logic                        op_err;
  logic [DATA_W-1:0]           rd_data;
  logic                        bus_start;
  logic [ACCESS_W-1:0]         bus_addr;
  logic [DATA_W-1:0]           bus_wr_data;
  logic                        bus_done;
  logic [DATA_W-1:0]           bus_rd_data;
  logic                        bus_abort;

  modport master (
    input  req, lock, req_addr, req_wr_data, bus_done, bus_rd_data,
    output grant, op_done, op_err, rd_data, bus_start, bus_addr, bus_wr_data, bus_abort
  );

  modport slave (
    output req, lock, req_addr, req_wr_data, bus_done, bus_rd_data,
    input  grant, op_done, op_err, rd_data, bus_start, bus_addr, bus_wr_data, bus_abort
  );
endinterface

// File: rtl/w5300_rr_pick.sv
// Combinational round-robin picker: first asserted request after last.
module w5300_rr_pick
  import w5300_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] win_oh_c,
  output logic [IDX_W-1:0]   win_idx_c,
  output logic               valid_c
);

  // Winner index and one-hot; one-hot is zero when nobody requests.
  always_comb begin
    valid_c   = |req;
    win_idx_c = rr_next(last, MAX_REQ'(req), NUM_REQ);
    win_oh_c  = valid_c ? (NUM_REQ'(1) << win_idx_c) : '0;
  end

endmodule

// File: rtl/w5300_bus_arbiter.sv
// Round-robin arbiter sharing the W5300 host-bus driver, with bus lock and watchdog.
module w5300_bus_arbiter
  import w5300_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TO_W           = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  w5300_bus_arbiter_if.master arb_if,
  output logic [TO_W-1:0]     err_cnt
);

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  arb_state_e         state, state_d;
  logic [IDX_W-1:0]   last_owner, last_owner_d;
  logic [TO_W-1:0]    wd_cnt, wd_cnt_d;
  logic [TO_W-1:0]    err_cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] op_done_q, op_done_d;
  logic               op_err_q, op_err_d;
  logic               bus_start_q, bus_start_d;
  logic               bus_abort_q, bus_abort_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  bus_req_t           bus_req_q, bus_req_d;

  logic [NUM_REQ-1:0] owner_oh_c;
  logic               lock_hold_c;
  logic [NUM_REQ-1:0] eligible_c;
  logic [NUM_REQ-1:0] win_oh_c;
  logic [IDX_W-1:0]   win_idx_c;
  logic               win_valid_c;
  bus_req_t           win_req_c;

  // A held lock restricts eligibility to the previous owner alone.
  always_comb begin
    owner_oh_c  = NUM_REQ'(1) << last_owner;
    lock_hold_c = |(arb_if.lock & owner_oh_c);
    eligible_c  = lock_hold_c ? (arb_if.req & owner_oh_c) : arb_if.req;
  end

  w5300_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req       (eligible_c),
    .last      (last_owner),
    .win_oh_c  (win_oh_c),
    .win_idx_c (win_idx_c),
    .valid_c   (win_valid_c)
  );

  // Select the winner's access word and write data.
  always_comb begin
    win_req_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_oh_c[i]) begin
        win_req_c.addr    = arb_if.req_addr[ACCESS_W*i +: ACCESS_W];
        win_req_c.wr_data = arb_if.req_wr_data[DATA_W*i +: DATA_W];
      end
    end
  end

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_d      = state;
    last_owner_d = last_owner;
    wd_cnt_d     = wd_cnt;
    err_cnt_d    = err_cnt;
    grant_d      = grant_q;
    op_done_d    = '0;
    op_err_d     = 1'b0;
    bus_start_d  = 1'b0;
    bus_abort_d  = 1'b0;
    rd_data_d    = rd_data_q;
    bus_req_d    = bus_req_q;
    unique case (state)
      ST_IDLE: begin
        if (win_valid_c) begin
          state_d      = ST_ISSUE;
          grant_d      = win_oh_c;
          bus_req_d    = win_req_c;
          last_owner_d = win_idx_c;
          bus_start_d  = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d  = ST_WAIT;
        wd_cnt_d = '0;
      end
      ST_WAIT: begin
        if (arb_if.bus_done) begin
          rd_data_d = arb_if.bus_rd_data;
          op_done_d = grant_q;
          grant_d   = '0;
          state_d   = ST_IDLE;
        end else if (wd_cnt == WD_LAST) begin
          bus_abort_d = 1'b1;
          op_done_d   = grant_q;
          op_err_d    = 1'b1;
          err_cnt_d   = (&err_cnt) ? err_cnt : err_cnt + TO_W'(1);
          grant_d     = '0;
          state_d     = ST_IDLE;
        end else begin
          wd_cnt_d = wd_cnt + TO_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_owner  <= IDX_W'(NUM_REQ - 1);
      wd_cnt      <= '0;
      err_cnt     <= '0;
      grant_q     <= '0;
      op_done_q   <= '0;
      op_err_q    <= 1'b0;
      bus_start_q <= 1'b0;
      bus_abort_q <= 1'b0;
      rd_data_q   <= '0;
      bus_req_q   <= '0;
    end else begin
      state       <= state_d;
      last_owner  <= last_owner_d;
      wd_cnt      <= wd_cnt_d;
      err_cnt     <= err_cnt_d;
      grant_q     <= grant_d;
      op_done_q   <= op_done_d;
      op_err_q    <= op_err_d;
      bus_start_q <= bus_start_d;
      bus_abort_q <= bus_abort_d;
      rd_data_q   <= rd_data_d;
      bus_req_q   <= bus_req_d;
    end
  end

  assign arb_if.grant       = grant_q;
  assign arb_if.op_done     = op_done_q;
  assign arb_if.op_err      = op_err_q;
  assign arb_if.rd_data     = rd_data_q;
  assign arb_if.bus_start   = bus_start_q;
  assign arb_if.bus_addr    = bus_req_q.addr;
  assign arb_if.bus_wr_data = bus_req_q.wr_data;
  assign arb_if.bus_abort   = bus_abort_q;

endmodule
